// File: rtl/bpb_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bpb_ctrl: lookup and update sequencer for a fully associative BPB.       |
// | Optional feature macro: BPB_CTRL_STATS_EN (hit/alloc/drop counters).     |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module bpb_ctrl #(
  parameter int ENTRIES   = 8,
  parameter int TAG_WIDTH = 30,
  parameter int QDEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    lk_pc,
  output logic                           lk_hit,
  output logic                           lk_taken,
  output logic [31:0]                    lk_target,
  input  logic                           up_valid,
  output logic                           up_ready,
  input  logic [31:0]                    up_pc,
  input  logic                           up_taken,
  input  logic [31:0]                    up_target,
  input  logic [ENTRIES-1:0]             line_valid,
  input  logic [ENTRIES*TAG_WIDTH-1:0]   line_tag,
  input  logic [ENTRIES*32-1:0]          line_addr,
  input  logic [ENTRIES-1:0]             line_pred,
  output logic [ENTRIES-1:0]             line_w_en,
  output logic [ENTRIES-1:0]             line_sw,
  output logic                           line_taken,
  output logic                           line_set_valid,
  output logic [TAG_WIDTH-1:0]           line_set_tag,
  output logic [31:0]                    line_set_addr,
  output logic                           busy
`ifdef BPB_CTRL_STATS_EN
  ,
  output logic [31:0]                    stat_hit,
  output logic [31:0]                    stat_alloc,
  output logic [31:0]                    stat_drop
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int PTR_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_WIDTH-1:0] fifo_tag_q [QDEPTH];
  logic                 fifo_taken_q [QDEPTH];
  logic [31:0]          fifo_tgt_q [QDEPTH];
  logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
  logic                 cur_taken_q, cur_taken_d;
  logic [31:0]          cur_tgt_q, cur_tgt_d;
  logic                 hit_q, hit_d, free_q, free_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;

  logic                 fifo_empty, fifo_full, push, pop;
  logic                 m_hit, m_free;
  logic [IDX_W-1:0]     m_hit_idx, m_free_idx, lk_idx;
  logic [31:0]          lk_addr;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (line_valid[i] && (line_tag[i*TAG_WIDTH +: TAG_WIDTH] == lk_pc[TAG_WIDTH+1:2])) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_W'(i);
        lk_addr = line_addr[i*32 +: 32];
      end
    end
    lk_taken  = lk_hit && line_pred[lk_idx];
    lk_target = lk_taken ? lk_addr : (lk_pc + 32'd4);
  end

  always_comb begin
    m_hit      = 1'b0;
    m_hit_idx  = '0;
    m_free     = 1'b0;
    m_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (line_valid[i] && (line_tag[i*TAG_WIDTH +: TAG_WIDTH] == cur_tag_q)) begin
        m_hit     = 1'b1;
        m_hit_idx = IDX_W'(i);
      end
      if (!line_valid[i]) begin
        m_free     = 1'b1;
        m_free_idx = IDX_W'(i);
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign up_ready   = !fifo_full;
  assign push       = up_valid && !fifo_full;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag_q[wr_ptr_q[PTR_W-1:0]]   <= up_pc[TAG_WIDTH+1:2];
      fifo_taken_q[wr_ptr_q[PTR_W-1:0]] <= up_taken;
      fifo_tgt_q[wr_ptr_q[PTR_W-1:0]]   <= up_target;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cur_tag_d   = cur_tag_q;
    cur_taken_d = cur_taken_q;
    cur_tgt_d   = cur_tgt_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        hit_d      = m_hit;
        hit_idx_d  = m_hit_idx;
        free_d     = m_free;
        free_idx_d = m_free_idx;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_MATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      cur_tag_d   = fifo_tag_q[rd_ptr_q[PTR_W-1:0]];
      cur_taken_d = fifo_taken_q[rd_ptr_q[PTR_W-1:0]];
      cur_tgt_d   = fifo_tgt_q[rd_ptr_q[PTR_W-1:0]];
    end
    wr_ptr_d = wr_ptr_q + (push ? (PTR_W+1)'(1) : '0);
    rd_ptr_d = rd_ptr_q + (pop ? (PTR_W+1)'(1) : '0);
  end

  // A taken miss with no free line is dropped: a valid line is never retagged.
  always_comb begin
    line_w_en      = '0;
    line_sw        = '0;
    line_taken     = 1'b0;
    line_set_valid = 1'b0;
    line_set_tag   = '0;
    line_set_addr  = '0;
    if (state_q == ST_ISSUE) begin
      if (hit_q) begin
        line_sw[hit_idx_q] = 1'b1;
        line_taken         = cur_taken_q;
      end else if (cur_taken_q && free_q) begin
        line_w_en[free_idx_q] = 1'b1;
        line_set_valid        = 1'b1;
        line_set_tag          = cur_tag_q;
        line_set_addr         = cur_tgt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cur_tag_q   <= '0;
      cur_taken_q <= 1'b0;
      cur_tgt_q   <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cur_tag_q   <= cur_tag_d;
      cur_taken_q <= cur_taken_d;
      cur_tgt_q   <= cur_tgt_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      free_q      <= free_d;
      free_idx_q  <= free_idx_d;
    end
  end

`ifdef BPB_CTRL_STATS_EN
  logic [31:0] stat_hit_q, stat_hit_d, stat_alloc_q, stat_alloc_d, stat_drop_q, stat_drop_d;

  always_comb begin
    stat_hit_d   = stat_hit_q;
    stat_alloc_d = stat_alloc_q;
    stat_drop_d  = stat_drop_q;
    if (state_q == ST_ISSUE) begin
      if (hit_q)
        stat_hit_d = stat_hit_q + 32'd1;
      else if (cur_taken_q && free_q)
        stat_alloc_d = stat_alloc_q + 32'd1;
      else if (cur_taken_q)
        stat_drop_d = stat_drop_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hit_q   <= '0;
      stat_alloc_q <= '0;
      stat_drop_q  <= '0;
    end else begin
      stat_hit_q   <= stat_hit_d;
      stat_alloc_q <= stat_alloc_d;
      stat_drop_q  <= stat_drop_d;
    end
  end

  assign stat_hit   = stat_hit_q;
  assign stat_alloc = stat_alloc_q;
  assign stat_drop  = stat_drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bpb_ctrl.sv
`default_nettype none
// tb_bpb_ctrl: randomized bench with a transaction-level reference model
// and a behavioural line array driven by the controller's strobes.
module tb_bpb_ctrl;
  localparam int ENTRIES = 8;
  localparam int TW      = 30;
  localparam int QDEPTH  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [31:0]             lk_pc, lk_target, up_pc, up_target;
  logic                    lk_hit, lk_taken, up_valid, up_ready, up_taken;
  logic [ENTRIES-1:0]      line_valid, line_pred, line_w_en, line_sw;
  logic [ENTRIES*TW-1:0]   line_tag;
  logic [ENTRIES*32-1:0]   line_addr;
  logic                    line_taken, line_set_valid, busy;
  logic [TW-1:0]           line_set_tag;
  logic [31:0]             line_set_addr;
`ifdef BPB_CTRL_STATS_EN
  logic [31:0]             stat_hit, stat_alloc, stat_drop;
`endif

  always #5 clk = ~clk;

  bpb_ctrl #(.ENTRIES(ENTRIES), .TAG_WIDTH(TW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc),
    .up_taken(up_taken), .up_target(up_target),
    .line_valid(line_valid), .line_tag(line_tag), .line_addr(line_addr),
    .line_pred(line_pred), .line_w_en(line_w_en), .line_sw(line_sw),
    .line_taken(line_taken), .line_set_valid(line_set_valid),
    .line_set_tag(line_set_tag), .line_set_addr(line_set_addr), .busy(busy)
`ifdef BPB_CTRL_STATS_EN
    , .stat_hit(stat_hit), .stat_alloc(stat_alloc), .stat_drop(stat_drop)
`endif
  );

  // Behavioural line array: allocation starts the counter weakly taken.
  logic [ENTRIES-1:0] env_valid;
  logic [TW-1:0]      env_tag [ENTRIES];
  logic [31:0]        env_addr [ENTRIES];
  logic [1:0]         env_cnt [ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        env_tag[i] <= '0; env_addr[i] <= '0; env_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (line_w_en[i]) begin
          env_valid[i] <= line_set_valid;
          env_tag[i]   <= line_set_tag;
          env_addr[i]  <= line_set_addr;
          env_cnt[i]   <= 2'b10;
        end else if (line_sw[i]) begin
          if (line_taken) env_cnt[i] <= (env_cnt[i] == 2'b11) ? 2'b11 : env_cnt[i] + 2'b01;
          else            env_cnt[i] <= (env_cnt[i] == 2'b00) ? 2'b00 : env_cnt[i] - 2'b01;
        end
      end
    end
  end

  always_comb begin
    line_valid = env_valid;
    line_tag   = '0;
    line_addr  = '0;
    line_pred  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      line_tag[i*TW +: TW] = env_tag[i];
      line_addr[i*32 +: 32] = env_addr[i];
      line_pred[i] = env_cnt[i][1];
    end
  end

  // Reference model: pending queue plus one in-flight update (age 0 = decide, 1 = write).
  typedef struct packed { logic [31:0] pc; logic taken; logic [31:0] tgt; } upd_t;
  upd_t q[$];
  upd_t cur;
  bit   inflight = 0;
  int   age = 0;
  int   m_hit = 0, m_alloc = 0, m_drop = 0;
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int find_tag(input logic [TW-1:0] t);
    for (int i = 0; i < ENTRIES; i++)
      if (env_valid[i] && env_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < ENTRIES; i++)
      if (!env_valid[i]) return i;
    return -1;
  endfunction

  task automatic cycle(input bit rst, input bit v, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input logic [31:0] lkpc);
    logic [ENTRIES-1:0] e_wen, e_sw;
    logic e_taken, e_sv, push_ok;
    logic [TW-1:0] e_tag;
    logic [31:0] e_addr, e_lkt;
    int h, f, li, kind;
    @(negedge clk);
    reset = rst; up_valid = v; up_pc = pc; up_taken = tk; up_target = tg; lk_pc = lkpc;
    if (rst) begin
      q.delete(); inflight = 0; age = 0; m_hit = 0; m_alloc = 0; m_drop = 0;
    end
    #1;
    e_wen = '0; e_sw = '0; e_taken = 0; e_sv = 0; e_tag = '0; e_addr = '0; kind = 0;
    if (inflight && age == 1) begin
      h = find_tag(cur.pc[TW+1:2]);
      f = find_free();
      if (h >= 0) begin e_sw[h] = 1'b1; e_taken = cur.taken; kind = 1; end
      else if (cur.taken && f >= 0) begin
        e_wen[f] = 1'b1; e_sv = 1'b1; e_tag = cur.pc[TW+1:2]; e_addr = cur.tgt; kind = 2;
      end else if (cur.taken) kind = 3;
    end
    li = find_tag(lkpc[TW+1:2]);
    e_lkt = (li >= 0 && env_cnt[li][1]) ? env_addr[li] : lkpc + 32'd4;
    check("line_w_en", 64'(line_w_en), 64'(e_wen));
    check("line_sw", 64'(line_sw), 64'(e_sw));
    check("line_taken", 64'(line_taken), 64'(e_taken));
    check("line_set_valid", 64'(line_set_valid), 64'(e_sv));
    check("line_set_tag", 64'(line_set_tag), 64'(e_tag));
    check("line_set_addr", 64'(line_set_addr), 64'(e_addr));
    check("up_ready", 64'(up_ready), 64'(q.size() < QDEPTH));
    check("busy", 64'(busy), 64'((q.size() != 0) || inflight));
    check("lk_hit", 64'(lk_hit), 64'(li >= 0));
    check("lk_taken", 64'(lk_taken), 64'(li >= 0 && env_cnt[li][1]));
    check("lk_target", 64'(lk_target), 64'(e_lkt));
`ifdef BPB_CTRL_STATS_EN
    check("stat_hit", 64'(stat_hit), 64'(m_hit));
    check("stat_alloc", 64'(stat_alloc), 64'(m_alloc));
    check("stat_drop", 64'(stat_drop), 64'(m_drop));
`endif
    push_ok = v && (q.size() < QDEPTH) && !rst;
    @(posedge clk);
    if (!rst) begin
      if (kind == 1) m_hit++;
      if (kind == 2) m_alloc++;
      if (kind == 3) m_drop++;
      if (inflight && age == 0) age = 1;
      else if (q.size() > 0) begin cur = q.pop_front(); inflight = 1; age = 0; end
      else inflight = 0;
      if (push_ok) q.push_back('{pc: pc, taken: tk, tgt: tg});
    end
  endtask

  task automatic idle(input int n, input logic [31:0] lkpc);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, 32'h0, lkpc);
  endtask

  initial begin
    bit hit_issue;
    reset = 1'b1; up_valid = 0; up_pc = '0; up_taken = 0; up_target = '0; lk_pc = '0;
    cycle(1, 0, 0, 0, 0, 32'h100);
    cycle(1, 0, 0, 0, 0, 32'h100);

    cycle(0, 1, 32'h100, 1, 32'h200, 32'h100);
    idle(4, 32'h100);
    check("alloc0_tag", 64'(env_tag[0]), 64'h40);
    check("alloc0_addr", 64'(env_addr[0]), 64'h200);
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h100, 1, 32'h200, 32'h100);
    idle(8, 32'h100);

    for (int k = 1; k < 8; k++) cycle(0, 1, 32'h1000 + 32'(4*k), 1, 32'h2000 + 32'(k), 32'h1000);
    cycle(0, 1, 32'h1ff0, 1, 32'h3000, 32'h1ff0);
    idle(24, 32'h1ff0);
    check("array_full", 64'(env_valid), 64'hff);

    for (int k = 0; k < 8; k++) cycle(0, 1, 32'h1004 + 32'(4*(k%3)), k[0], 32'h0, 32'h1004);
    idle(20, 32'h1004);

    cycle(1, 0, 0, 0, 0, 32'h300);
    cycle(0, 1, 32'h300, 0, 32'h500, 32'h300);
    idle(6, 32'h300);

    for (int n = 0; n < 500; n++) begin
      cycle(($urandom % 150) == 0, $urandom % 2, 32'h100 + 32'(4 * ($urandom % 12)),
            $urandom % 2, {$urandom, 2'b00} >> 2 << 2, 32'h100 + 32'(4 * ($urandom % 14)));
    end

    cycle(1, 0, 0, 0, 0, 32'h0);
    hit_issue = 0;
    for (int n = 0; n < 12 && !hit_issue; n++) begin
      if (inflight && age == 1 && q.size() >= 3) begin
        cycle(1, 0, 0, 0, 0, 32'h400);
        hit_issue = 1;
      end else begin
        cycle(0, 1, 32'h400 + 32'(4*n), 1, 32'h800, 32'h400);
      end
    end
    check("reset_in_issue_reached", 64'(hit_issue), 64'h1);
    idle(10, 32'h400);
    check("nothing_after_reset", 64'(env_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
